decode_stage: RTL and testbench

- Registered, parametrised RV32IM decode stage with valid/ready handshakes on both sides and a DEPTH-entry output buffer.
- Sits between instruction fetch and execute in each core of the two-core system.
- Produces the same control set as the combinational decoder, plus register indices, a sign-extended immediate, branch-condition encoding and multiply mode.
- Adds flush handling and a halt/drain state machine.

---
 rtl/decode_stage.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32IM decode stage: registered decode, DEPTH-entry record FIFO, flush and halt/drain FSM.
// Optional DECODE_ILLEGAL_TRAP_EN: flag illegal encodings and stop in TRAP after draining.
module decode_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned MUL_EN = 1
) (
    input  logic            clock,
    input  logic            nReset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alu_func,
    output logic [2:0]      wdata_sel,
    output logic [2:0]      op2_immediate,
    output logic            op1_pc,
    output logic            op1_zero,
    output logic            load_control,
    output logic            store_control,
    output logic [2:0]      mem_size,
    output logic            is_branch,
    output logic [2:0]      branch_cond,
    output logic [1:0]      jump_sel,
    output logic [1:0]      mul_mode,
    output logic            illegal,
    output logic            program_done,
    output logic            trap
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] HALT_INSTR = 32'h0000_006F;

    localparam logic [3:0] FADD   = 4'd0;
    localparam logic [3:0] FSUB   = 4'd1;
    localparam logic [3:0] FSLL   = 4'd2;
    localparam logic [3:0] FSLT   = 4'd3;
    localparam logic [3:0] FSLTU  = 4'd4;
    localparam logic [3:0] FXOR   = 4'd5;
    localparam logic [3:0] FSRL   = 4'd6;
    localparam logic [3:0] FSRA   = 4'd7;
    localparam logic [3:0] FOR    = 4'd8;
    localparam logic [3:0] FAND   = 4'd9;
    localparam logic [3:0] FMULT  = 4'd10;
    localparam logic [3:0] FMULTH = 4'd11;
    localparam logic [3:0] FNONE  = 4'd15;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_func;
        logic [2:0]      wdata_sel;
        logic [2:0]      op2_immediate;
        logic            op1_pc;
        logic            op1_zero;
        logic            load_control;
        logic            store_control;
        logic [2:0]      mem_size;
        logic            is_branch;
        logic [2:0]      branch_cond;
        logic [1:0]      jump_sel;
        logic [1:0]      mul_mode;
        logic            illegal;
    } rec_t;

    typedef enum logic [2:0] {S_RUN, S_DRAIN, S_DRAIN_T, S_HALT, S_TRAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            done_q, done_d, trap_q, trap_d;
    rec_t            fifo_q [DEPTH];
    rec_t            fifo_d [DEPTH];
    rec_t            dec, head;
    logic            bad_c, push_c, pop_c, flush_c;

    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    function automatic logic [3:0] base_alu(input logic [2:0] f);
        case (f)
            3'b000:  return FADD;
            3'b001:  return FSLL;
            3'b010:  return FSLT;
            3'b011:  return FSLTU;
            3'b100:  return FXOR;
            3'b101:  return FSRL;
            3'b110:  return FOR;
            default: return FAND;
        endcase
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Instruction decode; any unrecognised encoding collapses to a NOP record.
    always_comb begin
        dec          = '0;
        dec.alu_func = FNONE;
        dec.pc       = pc;
        bad_c        = 1'b0;
        case (instr[6:0])
            7'b0110111, 7'b0010111: begin
                dec.rd            = instr[11:7];
                dec.imm           = imm_u;
                dec.alu_func      = FADD;
                dec.op1_zero      = ~instr[5] ? 1'b0 : 1'b1;
                dec.op1_pc        = ~instr[5];
                dec.op2_immediate = 3'b011;
                dec.wdata_sel     = 3'b001;
            end
            7'b1101111: begin
                dec.rd        = instr[11:7];
                dec.imm       = imm_j;
                dec.jump_sel  = 2'b10;
                dec.wdata_sel = 3'b010;
            end
            7'b1100111: begin
                dec.rs1           = instr[19:15];
                dec.rd            = instr[11:7];
                dec.imm           = imm_i;
                dec.alu_func      = FADD;
                dec.op2_immediate = 3'b001;
                dec.jump_sel      = 2'b11;
                dec.wdata_sel     = 3'b010;
                bad_c             = (f3 != 3'b000);
            end
            7'b1100011: begin
                dec.rs1           = instr[19:15];
                dec.rs2           = instr[24:20];
                dec.imm           = imm_b;
                dec.alu_func      = FADD;
                dec.op1_pc        = 1'b1;
                dec.op2_immediate = 3'b100;
                dec.is_branch     = 1'b1;
                dec.branch_cond   = f3;
                bad_c             = (f3[2:1] == 2'b01);
            end
            7'b0000011: begin
                dec.rs1           = instr[19:15];
                dec.rd            = instr[11:7];
                dec.imm           = imm_i;
                dec.alu_func      = FADD;
                dec.op2_immediate = 3'b001;
                dec.load_control  = 1'b1;
                dec.mem_size      = f3;
                dec.wdata_sel     = 3'b100;
                bad_c             = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            7'b0100011: begin
                dec.rs1           = instr[19:15];
                dec.rs2           = instr[24:20];
                dec.imm           = imm_s;
                dec.alu_func      = FADD;
                dec.op2_immediate = 3'b010;
                dec.store_control = 1'b1;
                dec.mem_size      = f3;
                bad_c             = (f3[2] || f3 == 3'b011);
            end
            7'b0010011: begin
                dec.rs1           = instr[19:15];
                dec.rd            = instr[11:7];
                dec.imm           = imm_i;
                dec.op2_immediate = 3'b001;
                dec.wdata_sel     = 3'b001;
                dec.alu_func      = base_alu(f3);
                if (f3 == 3'b001) bad_c = (f7 != 7'h00);
                else if (f3 == 3'b101) begin
                    if (f7 == 7'h20) dec.alu_func = FSRA;
                    else bad_c = (f7 != 7'h00);
                end
            end
            7'b0110011: begin
                dec.rs1       = instr[19:15];
                dec.rs2       = instr[24:20];
                dec.rd        = instr[11:7];
                dec.wdata_sel = 3'b001;
                if (f7 == 7'h00) dec.alu_func = base_alu(f3);
                else if (f7 == 7'h20 && f3 == 3'b000) dec.alu_func = FSUB;
                else if (f7 == 7'h20 && f3 == 3'b101) dec.alu_func = FSRA;
                else if (f7 == 7'h01 && MUL_EN != 0 && !f3[2]) begin
                    dec.alu_func = (f3 == 3'b000) ? FMULT : FMULTH;
                    dec.mul_mode = f3[1:0];
                end
                else bad_c = 1'b1;
            end
            7'b0001111: ;
            default: bad_c = 1'b1;
        endcase
        if (bad_c) begin
            dec          = '0;
            dec.alu_func = FNONE;
            dec.pc       = pc;
            dec.illegal  = TRAP_EN;
        end
    end

    assign flush_c  = flush && (state_q != S_HALT) && (state_q != S_TRAP);
    assign in_ready = (state_q == S_RUN) && (count_q < CW'(DEPTH)) && !flush;
    assign out_valid = (count_q != '0);
    assign push_c   = in_valid && in_ready;
    assign pop_c    = out_valid && out_ready;

    // FIFO bookkeeping and halt/drain state machine.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fifo_d   = fifo_q;
        if (flush_c) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_c) begin
                fifo_d[wr_ptr_q] = dec;
                wr_ptr_d         = ptr_inc(wr_ptr_q);
            end
            if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
        case (state_q)
            S_RUN: begin
                if (push_c && instr == HALT_INSTR) state_d = S_DRAIN;
                else if (push_c && bad_c && TRAP_EN) state_d = S_DRAIN_T;
            end
            S_DRAIN: begin
                if (flush_c) state_d = S_RUN;
                else if (count_q == '0) state_d = S_HALT;
            end
            S_DRAIN_T: begin
                if (flush_c) state_d = S_RUN;
                else if (count_q == '0) state_d = S_TRAP;
            end
            default: ;
        endcase
        done_d = done_q || (state_d == S_HALT);
        trap_d = trap_q || (TRAP_EN && state_d == S_TRAP);
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_RUN;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
            trap_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i]          <= '0;
                fifo_q[i].alu_func <= FNONE;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= done_d;
            trap_q   <= trap_d;
            fifo_q   <= fifo_d;
        end
    end

    assign head          = fifo_q[rd_ptr_q];
    assign out_pc        = head.pc;
    assign rs1           = head.rs1;
    assign rs2           = head.rs2;
    assign rd            = head.rd;
    assign imm           = head.imm;
    assign alu_func      = head.alu_func;
    assign wdata_sel     = head.wdata_sel;
    assign op2_immediate = head.op2_immediate;
    assign op1_pc        = head.op1_pc;
    assign op1_zero      = head.op1_zero;
    assign load_control  = head.load_control;
    assign store_control = head.store_control;
    assign mem_size      = head.mem_size;
    assign is_branch     = head.is_branch;
    assign branch_cond   = head.branch_cond;
    assign jump_sel      = head.jump_sel;
    assign mul_mode      = head.mul_mode;
    assign illegal       = head.illegal;
    assign program_done  = done_q;
    assign trap          = trap_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic against a queue-based reference model.
module tb_decode_stage;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    localparam logic [3:0] FADD = 4'd0, FSUB = 4'd1, FSLL = 4'd2, FSLT = 4'd3, FSLTU = 4'd4;
    localparam logic [3:0] FXOR = 4'd5, FSRL = 4'd6, FSRA = 4'd7, FOR = 4'd8, FAND = 4'd9;
    localparam logic [3:0] FMULT = 4'd10, FMULTH = 4'd11, FNONE = 4'd15;
    localparam logic [31:0] ADD_X3 = 32'h002081B3;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_func;
        logic [2:0]  wdata_sel;
        logic [2:0]  op2_immediate;
        logic        op1_pc;
        logic        op1_zero;
        logic        load_control;
        logic        store_control;
        logic [2:0]  mem_size;
        logic        is_branch;
        logic [2:0]  branch_cond;
        logic [1:0]  jump_sel;
        logic [1:0]  mul_mode;
        logic        illegal;
    } exp_t;

    logic        clock = 1'b0, nReset = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
    logic [31:0] instr = '0, pc = '0, out_pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_func;
    logic [2:0]  wdata_sel, op2_immediate, mem_size, branch_cond;
    logic        op1_pc, op1_zero, load_control, store_control, is_branch, illegal, program_done, trap;
    logic [1:0]  jump_sel, mul_mode;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t obs;

    assign obs = {out_pc, rs1, rs2, rd, imm, alu_func, wdata_sel, op2_immediate, op1_pc, op1_zero,
                  load_control, store_control, mem_size, is_branch, branch_cond, jump_sel, mul_mode, illegal};

    always #5 clock = ~clock;

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .MUL_EN(1)) dut (
        .clock(clock), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2),
        .rd(rd), .imm(imm), .alu_func(alu_func), .wdata_sel(wdata_sel), .op2_immediate(op2_immediate),
        .op1_pc(op1_pc), .op1_zero(op1_zero), .load_control(load_control), .store_control(store_control),
        .mem_size(mem_size), .is_branch(is_branch), .branch_cond(branch_cond), .jump_sel(jump_sel),
        .mul_mode(mul_mode), .illegal(illegal), .program_done(program_done), .trap(trap)
    );

    // Reference decode written from the ISA field layout.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
        exp_t        r;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ok;
        logic [3:0]  tbl [8];
        tbl = '{FADD, FSLL, FSLT, FSLTU, FXOR, FSRL, FOR, FAND};
        f3 = w[14:12];
        f7 = w[31:25];
        ok = 1'b1;
        r = '0;
        r.pc = p;
        r.alu_func = FNONE;
        case (w[6:0])
            7'b0110111: begin
                r.rd = w[11:7]; r.imm = {w[31:12], 12'h000}; r.alu_func = FADD;
                r.op1_zero = 1'b1; r.op2_immediate = 3'b011; r.wdata_sel = 3'b001;
            end
            7'b0010111: begin
                r.rd = w[11:7]; r.imm = {w[31:12], 12'h000}; r.alu_func = FADD;
                r.op1_pc = 1'b1; r.op2_immediate = 3'b011; r.wdata_sel = 3'b001;
            end
            7'b1101111: begin
                r.rd = w[11:7]; r.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                r.jump_sel = 2'b10; r.wdata_sel = 3'b010;
            end
            7'b1100111: begin
                r.rs1 = w[19:15]; r.rd = w[11:7]; r.imm = {{20{w[31]}}, w[31:20]}; r.alu_func = FADD;
                r.op2_immediate = 3'b001; r.jump_sel = 2'b11; r.wdata_sel = 3'b010;
                ok = (f3 == 3'd0);
            end
            7'b1100011: begin
                r.rs1 = w[19:15]; r.rs2 = w[24:20];
                r.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                r.alu_func = FADD; r.op1_pc = 1'b1; r.op2_immediate = 3'b100;
                r.is_branch = 1'b1; r.branch_cond = f3;
                ok = (f3 != 3'd2) && (f3 != 3'd3);
            end
            7'b0000011: begin
                r.rs1 = w[19:15]; r.rd = w[11:7]; r.imm = {{20{w[31]}}, w[31:20]}; r.alu_func = FADD;
                r.op2_immediate = 3'b001; r.load_control = 1'b1; r.mem_size = f3; r.wdata_sel = 3'b100;
                ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
            end
            7'b0100011: begin
                r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                r.alu_func = FADD; r.op2_immediate = 3'b010; r.store_control = 1'b1; r.mem_size = f3;
                ok = (f3 <= 3'd2);
            end
            7'b0010011: begin
                r.rs1 = w[19:15]; r.rd = w[11:7]; r.imm = {{20{w[31]}}, w[31:20]};
                r.op2_immediate = 3'b001; r.wdata_sel = 3'b001; r.alu_func = tbl[f3];
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) begin
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                    if (f7 == 7'h20) r.alu_func = FSRA;
                end
            end
            7'b0110011: begin
                r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7]; r.wdata_sel = 3'b001;
                if (f7 == 7'h00) r.alu_func = tbl[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) r.alu_func = FSUB;
                else if (f7 == 7'h20 && f3 == 3'd5) r.alu_func = FSRA;
                else if (f7 == 7'h01 && f3 < 3'd4) begin
                    r.alu_func = (f3 == 3'd0) ? FMULT : FMULTH;
                    r.mul_mode = f3[1:0];
                end else ok = 1'b0;
            end
            7'b0001111: ;
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            r = '0; r.pc = p; r.alu_func = FNONE; r.illegal = TRAP_EN;
        end
        return r;
    endfunction

    // Random legal RV32IM word, never the halt encoding.
    function automatic logic [31:0] gen_instr();
        logic [4:0]  a, b, d;
        logic [2:0]  f3;
        logic [31:0] w;
        logic [2:0]  ld [5];
        logic [2:0]  br [6];
        ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        br = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        a  = 5'($urandom); b = 5'($urandom); d = 5'($urandom); f3 = 3'($urandom);
        case ($urandom_range(0, 9))
            0: w = {((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                    b, a, f3, d, 7'b0110011};
            1: begin
                if (f3 == 3'd1) w = {7'h00, b, a, f3, d, 7'b0010011};
                else if (f3 == 3'd5) w = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, b, a, f3, d, 7'b0010011};
                else w = {12'($urandom), a, f3, d, 7'b0010011};
            end
            2: w = {12'($urandom), a, ld[$urandom_range(0, 4)], d, 7'b0000011};
            3: w = {7'($urandom), b, a, 3'($urandom_range(0, 2)), d, 7'b0100011};
            4: w = {7'($urandom), b, a, br[$urandom_range(0, 5)], d, 7'b1100011};
            5: w = {20'($urandom), d, 7'b0110111};
            6: w = {20'($urandom), d, 7'b0010111};
            7: begin
                w = {20'($urandom), d, 7'b1101111};
                if (w == 32'h0000006F) w[7] = 1'b1;
            end
            8: w = {12'($urandom), a, 3'b000, d, 7'b1100111};
            default: w = {7'h01, b, a, {1'b0, f3[1:0]}, d, 7'b0110011};
        endcase
        return w;
    endfunction

    task automatic do_reset();
        nReset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
        repeat (2) @(negedge clock);
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        e = '0;
        e.alu_func = FNONE;
        nReset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (obs !== e) begin
            errors++; $display("FAIL reset_fields: got %h want %h", obs, e);
        end
        checks++;
        if ({out_valid, program_done, trap} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {out_valid, program_done, trap});
        end
        nReset = 1'b1;
    endtask

    task automatic test_add();
        in_valid = 1'b1; instr = ADD_X3; pc = 32'h100; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, rs1, rs2, rd, alu_func, wdata_sel, out_pc, imm} !==
            {1'b1, 5'd1, 5'd2, 5'd3, FADD, 3'b001, 32'h100, 32'h0}) begin
            errors++;
            $display("FAIL add_decode: got v=%b rs=%0d/%0d/%0d alu=%0d wd=%b pc=%h imm=%h want 1 1/2/3 %0d 001 100 0",
                     out_valid, rs1, rs2, rd, alu_func, wdata_sel, out_pc, imm, FADD);
        end
        @(negedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clock);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093; pc = 32'h200;
        @(negedge clock);
        instr = 32'h0040A283; pc = 32'h204;
        @(negedge clock);
        instr = 32'h00000013; pc = 32'h208;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++; $display("FAIL bp_full: got ready=%b valid=%b want 0 1", in_ready, out_valid);
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({imm, rd, out_pc, load_control} !== {32'd5, 5'd1, 32'h200, 1'b0}) begin
            errors++; $display("FAIL bp_head_held: got imm=%h rd=%0d pc=%h ld=%b want 5 1 200 0", imm, rd, out_pc, load_control);
        end
        out_ready = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if ({out_valid, imm, load_control, rd, rs1, mem_size, wdata_sel, op2_immediate, out_pc} !==
            {1'b1, 32'd4, 1'b1, 5'd5, 5'd1, 3'b010, 3'b100, 3'b001, 32'h204}) begin
            errors++; $display("FAIL bp_second: got imm=%h ld=%b rd=%0d sz=%b wd=%b pc=%h want 4 1 5 010 100 204",
                               imm, load_control, rd, mem_size, wdata_sel, out_pc);
        end
        @(negedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_branch();
        @(negedge clock);
        in_valid = 1'b1; instr = 32'h00208463; pc = 32'h300; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, is_branch, branch_cond, op1_pc, op2_immediate, alu_func, imm, rs1, rs2, rd, wdata_sel} !==
            {1'b1, 1'b1, 3'b000, 1'b1, 3'b100, FADD, 32'd8, 5'd1, 5'd2, 5'd0, 3'b000}) begin
            errors++; $display("FAIL branch_decode: got br=%b c=%b pc1=%b op2=%b alu=%0d imm=%h rd=%0d want 1 000 1 100 0 8 0",
                               is_branch, branch_cond, op1_pc, op2_immediate, alu_func, imm, rd);
        end
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_mulh();
        @(negedge clock);
        in_valid = 1'b1; instr = 32'h022091B3; pc = 32'h310; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, alu_func, mul_mode, rd, rs1, rs2, wdata_sel} !==
            {1'b1, FMULTH, 2'b01, 5'd3, 5'd1, 5'd2, 3'b001}) begin
            errors++; $display("FAIL mulh_decode: got alu=%0d mode=%b rd=%0d wd=%b want %0d 01 3 001",
                               alu_func, mul_mode, rd, wdata_sel, FMULTH);
        end
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic push, pop;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = gen_instr();
            pc        = $urandom & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, out_valid, q.size() != 0);
            end
            checks++;
            if (in_ready !== (!flush && q.size() < DEPTH)) begin
                errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, in_ready, !flush && q.size() < DEPTH);
            end
            if (q.size() != 0) begin
                checks++;
                if (obs !== q[0]) begin
                    errors++; $display("FAIL rand_head cyc %0d: got %h want %h", cyc, obs, q[0]);
                end
            end
            push = in_valid && !flush && (q.size() < DEPTH);
            pop  = (q.size() != 0) && out_ready;
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(model(instr, pc));
            end
        end
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        q.delete();
    endtask

    task automatic test_illegal();
        exp_t e;
        e = '0; e.alu_func = FNONE; e.pc = 32'h400; e.illegal = TRAP_EN;
        @(negedge clock);
        in_valid = 1'b1; instr = 32'hFFFFFFFF; pc = 32'h400; out_ready = 1'b0;
        @(negedge clock);
        instr = ADD_X3; pc = 32'h404;
        #1;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL illegal_record: got %h want %h", obs, e); end
`ifdef DECODE_ILLEGAL_TRAP_EN
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL illegal_stall: got %b want 0", in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6 && trap !== 1'b1; i++) @(negedge clock);
        #1;
        checks++;
        if ({trap, out_valid, in_ready, program_done} !== 4'b1000) begin
            errors++; $display("FAIL illegal_trap: got trap=%b v=%b rdy=%b done=%b want 1 0 0 0", trap, out_valid, in_ready, program_done);
        end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
        checks++;
        if (trap !== 1'b1) begin errors++; $display("FAIL trap_sticky: got %b want 1", trap); end
        do_reset();
        #1;
        checks++;
        if (trap !== 1'b0) begin errors++; $display("FAIL trap_reset: got %b want 0", trap); end
`else
        checks++;
        if ({in_ready, trap} !== 2'b10) begin
            errors++; $display("FAIL illegal_continue: got rdy=%b trap=%b want 1 0", in_ready, trap);
        end
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, rd, alu_func, out_pc} !== {1'b1, 5'd3, FADD, 32'h404}) begin
            errors++; $display("FAIL illegal_next: got v=%b rd=%0d alu=%0d pc=%h want 1 3 0 404", out_valid, rd, alu_func, out_pc);
        end
        @(negedge clock);
        out_ready = 1'b0;
`endif
    endtask

    task automatic test_flush_drain();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0000006F; pc = 32'h500;
        @(negedge clock);
        instr = ADD_X3; pc = 32'h504;
        #1;
        checks++;
        if ({in_ready, out_valid, jump_sel, wdata_sel, rd, imm} !== {1'b0, 1'b1, 2'b10, 3'b010, 5'd0, 32'd0}) begin
            errors++; $display("FAIL drain_halt_rec: got rdy=%b v=%b js=%b wd=%b want 0 1 10 010", in_ready, out_valid, jump_sel, wdata_sel);
        end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, program_done} !== 3'b010) begin
            errors++; $display("FAIL drain_flush: got v=%b rdy=%b done=%b want 0 1 0", out_valid, in_ready, program_done);
        end
        in_valid = 1'b1; instr = ADD_X3; pc = 32'h600; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({out_valid, in_ready, program_done} !== 3'b010) begin
            errors++; $display("FAIL drain_resume: got v=%b rdy=%b done=%b want 0 1 0", out_valid, in_ready, program_done);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0000006F; pc = 32'h700;
        @(negedge clock);
        instr = ADD_X3; pc = 32'h704;
        repeat (3) begin
            #1;
            checks++;
            if ({in_ready, program_done, out_valid} !== 3'b001) begin
                errors++; $display("FAIL halt_hold: got rdy=%b done=%b v=%b want 0 0 1", in_ready, program_done, out_valid);
            end
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if ({out_valid, program_done} !== 2'b00) begin
            errors++; $display("FAIL halt_popped: got v=%b done=%b want 0 0", out_valid, program_done);
        end
        @(negedge clock);
        #1;
        checks++;
        if ({program_done, in_ready} !== 2'b10) begin
            errors++; $display("FAIL halt_done: got done=%b rdy=%b want 1 0", program_done, in_ready);
        end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
        checks++;
        if ({program_done, in_ready, out_valid} !== 3'b100) begin
            errors++; $display("FAIL halt_flush: got done=%b rdy=%b v=%b want 1 0 0", program_done, in_ready, out_valid);
        end
        in_valid = 1'b0;
        do_reset();
        #1;
        checks++;
        if ({program_done, in_ready} !== 2'b01) begin
            errors++; $display("FAIL halt_reset: got done=%b rdy=%b want 0 1", program_done, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_branch();
        test_mulh();
        test_random();
        test_illegal();
        test_flush_drain();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
